// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesters (fetch, load/store), the arbiter and the BRAM.
// The slave view belongs to the arbiter; the master view to whoever drives requests and models memory.
interface memory_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_strb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_r_en;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_r_data;
  logic        mem_w_en;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_w_strb;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata, d_strb,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_r_en, mem_r_addr,
    input  mem_r_data,
    output mem_w_en, mem_w_addr, mem_w_data, mem_w_strb
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata, d_strb,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_r_en, mem_r_addr,
    output mem_r_data,
    input  mem_w_en, mem_w_addr, mem_w_data, mem_w_strb
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between instruction fetch and load/store.
// Bad (misaligned / out-of-range) accesses are answered with an error and never reach memory.
module memory_arbiter_checker (
  input logic clk,
  input logic rst_n,
  input logic if_gnt,
  input logic d_gnt,
  input logic mem_r_en,
  input logic mem_w_en,
  input logic if_rvalid,
  input logic d_rvalid
);
  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(if_gnt && d_gnt));
  a_one_mem_op: assert property (@(posedge clk) disable iff (!rst_n) !(mem_r_en && mem_w_en));
  a_one_response: assert property (@(posedge clk) disable iff (!rst_n) !(if_rvalid && d_rvalid));
endmodule

module memory_arbiter #(
  parameter int unsigned MEMORY_SIZE_WORDS = 32'd1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_enable,
  output logic mem_clk_enable,
  memory_arbiter_if.slave bus
);

  typedef enum logic {
    PRIO_DATA  = 1'b0,
    PRIO_FETCH = 1'b1
  } prio_e;

  prio_e       prio_r;
  prio_e       prio_nxt_s;
  logic        gnt_if_s;
  logic        gnt_d_s;
  logic        err_if_s;
  logic        err_d_s;

  logic        mem_r_en_s;
  logic [31:0] mem_r_addr_s;
  logic        mem_w_en_s;
  logic [31:0] mem_w_addr_s;
  logic [31:0] mem_w_data_s;
  logic [3:0]  mem_w_strb_s;

  logic        if_rvalid_r;
  logic        if_err_r;
  logic        d_rvalid_r;
  logic        d_err_r;
  logic        d_read_r;

  function automatic logic access_err(input logic [31:0] addr);
    logic [31:0] word_idx;
    word_idx   = {2'b00, addr[31:2]};
    access_err = (addr[1:0] != 2'b00) || (word_idx >= MEMORY_SIZE_WORDS);
  endfunction

  assign err_if_s = access_err(bus.if_addr);
  assign err_d_s  = access_err(bus.d_addr);

  // Grant selection and next priority; the side just served always yields priority.
  always_comb begin
    gnt_if_s   = 1'b0;
    gnt_d_s    = 1'b0;
    prio_nxt_s = prio_r;
    if (clk_enable) begin
      case ({bus.if_req, bus.d_req})
        2'b10: begin
          gnt_if_s   = 1'b1;
          prio_nxt_s = PRIO_DATA;
        end
        2'b01: begin
          gnt_d_s    = 1'b1;
          prio_nxt_s = PRIO_FETCH;
        end
        2'b11: begin
          if (prio_r == PRIO_DATA) begin
            gnt_d_s    = 1'b1;
            prio_nxt_s = PRIO_FETCH;
          end else begin
            gnt_if_s   = 1'b1;
            prio_nxt_s = PRIO_DATA;
          end
        end
        default: begin
          prio_nxt_s = prio_r;
        end
      endcase
    end else begin
      prio_nxt_s = prio_r;
    end
  end

  // Memory command for the granted, error-free access; idle bus is all zeros.
  always_comb begin
    mem_r_en_s   = 1'b0;
    mem_r_addr_s = 32'h0000_0000;
    mem_w_en_s   = 1'b0;
    mem_w_addr_s = 32'h0000_0000;
    mem_w_data_s = 32'h0000_0000;
    mem_w_strb_s = 4'b0000;
    if (gnt_if_s && !err_if_s) begin
      mem_r_en_s   = 1'b1;
      mem_r_addr_s = bus.if_addr;
    end else if (gnt_d_s && !err_d_s) begin
      if (bus.d_we) begin
        mem_w_en_s   = 1'b1;
        mem_w_addr_s = bus.d_addr;
        mem_w_data_s = bus.d_wdata;
        mem_w_strb_s = bus.d_strb;
      end else begin
        mem_r_en_s   = 1'b1;
        mem_r_addr_s = bus.d_addr;
      end
    end else begin
      mem_r_en_s = 1'b0;
      mem_w_en_s = 1'b0;
    end
  end

  // Priority and response tracking; everything freezes while clk_enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r      <= PRIO_DATA;
      if_rvalid_r <= 1'b0;
      if_err_r    <= 1'b0;
      d_rvalid_r  <= 1'b0;
      d_err_r     <= 1'b0;
      d_read_r    <= 1'b0;
    end else if (clk_enable) begin
      prio_r      <= prio_nxt_s;
      if_rvalid_r <= gnt_if_s;
      if_err_r    <= gnt_if_s & err_if_s;
      d_rvalid_r  <= gnt_d_s;
      d_err_r     <= gnt_d_s & err_d_s;
      d_read_r    <= gnt_d_s & ~bus.d_we;
    end
  end

  assign bus.if_gnt     = gnt_if_s;
  assign bus.d_gnt      = gnt_d_s;
  assign bus.mem_r_en   = mem_r_en_s;
  assign bus.mem_r_addr = mem_r_addr_s;
  assign bus.mem_w_en   = mem_w_en_s;
  assign bus.mem_w_addr = mem_w_addr_s;
  assign bus.mem_w_data = mem_w_data_s;
  assign bus.mem_w_strb = mem_w_strb_s;
  assign mem_clk_enable = clk_enable;

  // Read data comes straight from the BRAM output register, which holds with clk_enable.
  assign bus.if_rvalid = if_rvalid_r;
  assign bus.if_err    = if_err_r;
  assign bus.if_rdata  = (if_rvalid_r && !if_err_r) ? bus.mem_r_data : 32'h0000_0000;
  assign bus.d_rvalid  = d_rvalid_r;
  assign bus.d_err     = d_err_r;
  assign bus.d_rdata   = (d_rvalid_r && !d_err_r && d_read_r) ? bus.mem_r_data : 32'h0000_0000;

  memory_arbiter_checker u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_gnt    (gnt_if_s),
    .d_gnt     (gnt_d_s),
    .mem_r_en  (mem_r_en_s),
    .mem_w_en  (mem_w_en_s),
    .if_rvalid (if_rvalid_r),
    .d_rvalid  (d_rvalid_r)
  );

endmodule
